bw_clk_cclk_mon: RTL and testbench

Leaf-end monitor for the distributed cclk tree: samples a buffered/inverted cclk tap as asynchronous data in the reference clock domain, measures its period and reports lock, stuck-clock and out-of-range frequency faults. Placed at a cluster leaf beside the cclk drivers. Results feed the clock-control CSR block and test logic.

---
 rtl/bw_clk_mon_pkg.sv | 9 +
 rtl/bw_clk_sync2.sv | 20 ++
 rtl/bw_clk_cclk_mon.sv | 100 ++++++++++
 tb/tb_bw_clk_cclk_mon.sv | 114 +++++++++++
 4 files changed

// File: rtl/bw_clk_mon_pkg.sv
// bw_clk_mon_pkg: FSM state encoding and parameter legality check for the cclk monitor
package bw_clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_e;
  localparam int MAX_CNT_W = 30;
  function automatic bit params_ok(int cnt_w, int min_per, int max_per, int lock_cnt, int timeout);
    return cnt_w >= 2 && cnt_w <= MAX_CNT_W && min_per >= 1 && min_per <= max_per &&
           max_per < timeout && timeout <= (1 << cnt_w) - 1 && lock_cnt >= 1;
  endfunction
endpackage

// File: rtl/bw_clk_sync2.sv
// bw_clk_sync2: two-flop synchronizer with synchronous active-low reset to 0
module bw_clk_sync2 (
  input  logic rclk,
  input  logic rst_l,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // shift the async input through two flops to settle metastability
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/bw_clk_cclk_mon.sv
// bw_clk_cclk_mon: measures cclk period in rclk cycles and reports lock, stuck and frequency faults
module bw_clk_cclk_mon
  import bw_clk_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MIN_PER  = 4,
  parameter int MAX_PER  = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             rclk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             cclk_in,
  input  logic             err_clr,
  output logic             lock,
  output logic             stuck_err,
  output logic             freq_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  if (!params_ok(CNT_W, MIN_PER, MAX_PER, LOCK_CNT, TIMEOUT)) begin : g_bad_params
    $error("bw_clk_cclk_mon: illegal parameter set");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic             s2, s3_q, first_seen_q, first_seen_d;
  logic             stuck_q, stuck_d, freq_q, freq_d, lock_q, lock_d, vld_q, vld_d;
  logic             act, rise, meas, in_rng, tmo, set_stuck, set_freq;
  bw_clk_sync2 u_sync (.rclk(rclk), .rst_l(rst_l), .d(cclk_in), .q(s2));
  // edge detect, period counter, acquisition FSM and next-state of all outputs
  always_comb begin
    act          = state_q == ACQ || state_q == LOCKED;
    rise         = s2 & ~s3_q;
    meas         = en && act && rise && first_seen_q;
    in_rng       = cnt_q >= CNT_W'(MIN_PER) && cnt_q <= CNT_W'(MAX_PER);
    tmo          = en && act && !rise && cnt_q == CNT_W'(TIMEOUT);
    good_inc     = good_q + GW'(1);
    cnt_d        = state_q == IDLE ? '0 : rise ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    first_seen_d = en && act && (first_seen_q || rise);
    state_d      = state_q;
    good_d       = '0;
    set_stuck    = 1'b0;
    set_freq     = 1'b0;
    case (state_q)
      IDLE:   state_d = en ? ACQ : IDLE;
      ACQ: begin
        good_d    = meas ? (in_rng ? good_inc : '0) : good_q;
        set_stuck = tmo;
        state_d   = tmo ? FAULT : (meas && in_rng && good_inc == GW'(LOCK_CNT)) ? LOCKED : ACQ;
      end
      LOCKED: begin
        set_stuck = tmo;
        set_freq  = !tmo && meas && !in_rng;
        state_d   = (set_stuck || set_freq) ? FAULT : LOCKED;
      end
      FAULT:  state_d = err_clr ? ACQ : FAULT;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
    stuck_d  = set_stuck | (stuck_q & ~err_clr);
    freq_d   = set_freq | (freq_q & ~err_clr);
    period_d = meas ? cnt_q : period_q;
    vld_d    = meas;
    lock_d   = state_d == LOCKED;
  end
  // single register bank; reset returns every flop to its idle value
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      s3_q         <= 1'b0;
      first_seen_q <= 1'b0;
      stuck_q      <= 1'b0;
      freq_q       <= 1'b0;
      lock_q       <= 1'b0;
      period_q     <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      s3_q         <= s2;
      first_seen_q <= first_seen_d;
      stuck_q      <= stuck_d;
      freq_q       <= freq_d;
      lock_q       <= lock_d;
      period_q     <= period_d;
      vld_q        <= vld_d;
    end
  end
  assign lock       = lock_q;
  assign stuck_err  = stuck_q;
  assign freq_err   = freq_q;
  assign period     = period_q;
  assign period_vld = vld_q;
endmodule

// File: tb/tb_bw_clk_cclk_mon.sv
// tb_bw_clk_cclk_mon: directed checks of period measurement, lock, stuck and frequency faults
module tb_bw_clk_cclk_mon;
  logic       rclk = 1'b0, rst_l, en, cclk_in, err_clr;
  logic       lock, stuck_err, freq_err, period_vld;
  logic [7:0] period;
  int         total = 0, bad = 0, vld_cnt = 0, last_per = 0, v0;
  bw_clk_cclk_mon dut (
    .rclk(rclk), .rst_l(rst_l), .en(en), .cclk_in(cclk_in), .err_clr(err_clr),
    .lock(lock), .stuck_err(stuck_err), .freq_err(freq_err),
    .period(period), .period_vld(period_vld)
  );
  always #5 rclk = ~rclk;
  // record every period_vld pulse, sampled away from the active edge
  always @(negedge rclk) if (period_vld) begin
    vld_cnt++;
    last_per = period;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge rclk);
  endtask
  task automatic cyc(input int p);
    cclk_in = 1'b1;
    idle(p / 2);
    cclk_in = 1'b0;
    idle(p - p / 2);
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask
  initial begin
    rst_l = 1'b0; en = 1'b1; cclk_in = 1'b0; err_clr = 1'b0;
    idle(2);
    repeat (4) cyc(8);
    chk("rst_lock", lock, 0);
    chk("rst_stuck", stuck_err, 0);
    chk("rst_freq", freq_err, 0);
    chk("rst_period", period, 0);
    chk("rst_vld_cnt", vld_cnt, 0);
    en = 1'b0; rst_l = 1'b1;
    idle(2);
    en = 1'b1;
    idle(2);
    v0 = vld_cnt;
    repeat (4) cyc(8);
    chk("acq_vld3", vld_cnt - v0, 3);
    chk("acq_nolock", lock, 0);
    cyc(8);
    chk("acq_vld4", vld_cnt - v0, 4);
    chk("acq_per8", last_per, 8);
    chk("acq_lock", lock, 1);
    chk("acq_noerr", stuck_err | freq_err, 0);
    idle(40);
    chk("hold_lock", lock, 1);
    chk("hold_nostuck", stuck_err, 0);
    idle(30);
    chk("stuck_set", stuck_err, 1);
    chk("stuck_nolock", lock, 0);
    v0 = vld_cnt;
    repeat (3) cyc(8);
    chk("stuck_sticky", stuck_err, 1);
    chk("fault_nolock", lock, 0);
    chk("fault_novld", vld_cnt - v0, 0);
    pulse_clr();
    chk("clr_stuck", stuck_err, 0);
    chk("clr_freq", freq_err, 0);
    repeat (4) cyc(8);
    chk("relock1_early", lock, 0);
    cyc(8);
    chk("relock1", lock, 1);
    cyc(20);
    cyc(8);
    chk("freq_per20", last_per, 20);
    chk("freq_set", freq_err, 1);
    chk("freq_nolock", lock, 0);
    chk("freq_nostuck", stuck_err, 0);
    pulse_clr();
    chk("clr2_freq", freq_err, 0);
    repeat (4) cyc(8);
    chk("relock2_early", lock, 0);
    cyc(8);
    chk("relock2", lock, 1);
    en = 1'b0;
    idle(1);
    chk("en_off_lock", lock, 0);
    idle(3);
    en = 1'b1;
    idle(2);
    v0 = vld_cnt;
    cyc(8);
    chk("en_first_novld", vld_cnt - v0, 0);
    cyc(8);
    cyc(3);
    cyc(8);
    chk("short_per3", last_per, 3);
    chk("short_noerr", freq_err | stuck_err, 0);
    repeat (3) cyc(8);
    chk("short_nolock", lock, 0);
    chk("short_vld6", vld_cnt - v0, 6);
    cyc(8);
    chk("short_relock", lock, 1);
    chk("short_per8", last_per, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
